// File: rtl/core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// core_ctrl_fsm
//   Multi-cycle control sequencer for the NPC core. Owns the PC and the
//   instruction register, drives the fetch and store handshakes, gates the
//   register-file write and picks the next PC. It halts on ebreak or on a
//   word the decoder does not recognise.
//
//   Optional feature macro: CORE_CTRL_PERF_CNT_EN
//     defined   -> perf_cycle / perf_instret are live 64-bit counters
//     undefined -> both outputs are tied to zero and no counter flops exist
//
// Ports
//   clk, rst                 core clock (rising edge), async active-high reset
//   ifu_req_valid/ready      fetch request handshake, ifu_addr = pc
//   ifu_rsp_valid/data       fetch response, consumed only while waiting
//   inst_q                   latched instruction word, feeds the decoder
//   dec_flags                one-hot decoder flags (see bit map below)
//   exu_br_taken, exu_target branch condition and redirect target from EXU
//   lsu_req_valid/ready      store request handshake
//   rf_wen                   register-file write enable
//   pc                       current PC
//   halt, halt_illegal       core halted / halted on undecodable word
//   perf_cycle, perf_instret performance counters
//
//   dec_flags: [0]add [1]sub [2]and [3]addi [4]auipc [5]lui [6]jal [7]jalr
//              [8]beq [9]bne [10]blt [11]bge [12]bltu [13]bgeu [14]sw
//              [15]ebreak
// -----------------------------------------------------------------------------
module core_ctrl_fsm #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  output logic [31:0]     inst_q,
  input  logic [15:0]     dec_flags,
  input  logic            exu_br_taken,
  input  logic [XLEN-1:0] exu_target,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  output logic            rf_wen,
  output logic [XLEN-1:0] pc,
  output logic            halt,
  output logic            halt_illegal,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_WAIT_IF = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  state_e state_r;
  state_e next_state_s;

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_n_s;
  logic [31:0]     inst_q_r;
  logic [31:0]     inst_q_n_s;
  logic            ifu_req_valid_r;
  logic            ifu_req_valid_n_s;
  logic            lsu_req_valid_r;
  logic            lsu_req_valid_n_s;
  logic            rf_wen_r;
  logic            rf_wen_n_s;
  logic            halt_r;
  logic            halt_n_s;
  logic            halt_illegal_r;
  logic            halt_illegal_n_s;

  // Instruction classes derived from the decoder flags.
  logic is_writer_s;
  logic is_branch_s;
  logic is_jump_s;
  logic is_sw_s;
  logic is_ebreak_s;
  logic no_flags_s;
  logic writes_rd_s;
  logic redirect_s;

  assign is_writer_s = |dec_flags[7:0];
  assign is_branch_s = |dec_flags[13:8];
  assign is_jump_s   = dec_flags[6] | dec_flags[7];
  assign is_sw_s     = dec_flags[14];
  assign is_ebreak_s = dec_flags[15];
  assign no_flags_s  = (dec_flags == 16'h0000);
  // x0 is hard-wired, so a write to rd=0 is suppressed here.
  assign writes_rd_s = is_writer_s && (inst_q_r[11:7] != 5'd0);
  assign redirect_s  = is_jump_s || (is_branch_s && exu_br_taken);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; handshakes use the registered valids the bus sees.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (ifu_req_valid_r && ifu_req_ready) begin
          next_state_s = ST_WAIT_IF;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_WAIT_IF: begin
        if (ifu_rsp_valid) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_WAIT_IF;
        end
      end
      ST_EXEC: begin
        // ebreak outranks every other flag, including jal on 32'h0000006f.
        if (is_ebreak_s) begin
          next_state_s = ST_HALT;
        end else if (no_flags_s) begin
          next_state_s = ST_HALT;
        end else if (is_sw_s) begin
          next_state_s = ST_MEM;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (lsu_req_valid_r && lsu_req_ready) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB:   next_state_s = ST_FETCH;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Output/datapath next values; outputs are decoded from the next state so
  // the registered copies line up with the state they describe.
  always_comb begin
    ifu_req_valid_n_s = (next_state_s == ST_FETCH);
    lsu_req_valid_n_s = (next_state_s == ST_MEM);
    rf_wen_n_s        = (next_state_s == ST_WB) && writes_rd_s;
    halt_n_s          = (next_state_s == ST_HALT);

    if ((state_r == ST_EXEC) && !is_ebreak_s && no_flags_s) begin
      halt_illegal_n_s = 1'b1;
    end else begin
      halt_illegal_n_s = halt_illegal_r;
    end

    // Responses outside WAIT_IF are strays and must not disturb inst_q.
    if ((state_r == ST_WAIT_IF) && ifu_rsp_valid) begin
      inst_q_n_s = ifu_rsp_data;
    end else begin
      inst_q_n_s = inst_q_r;
    end

    if (state_r == ST_WB) begin
      if (redirect_s) begin
        pc_n_s = exu_target;
      end else begin
        pc_n_s = pc_r + PC_STEP;
      end
    end else begin
      pc_n_s = pc_r;
    end
  end

  // Registered outputs and datapath; reset clears valids immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r            <= RESET_PC;
      inst_q_r        <= 32'h0000_0000;
      ifu_req_valid_r <= 1'b0;
      lsu_req_valid_r <= 1'b0;
      rf_wen_r        <= 1'b0;
      halt_r          <= 1'b0;
      halt_illegal_r  <= 1'b0;
    end else begin
      pc_r            <= pc_n_s;
      inst_q_r        <= inst_q_n_s;
      ifu_req_valid_r <= ifu_req_valid_n_s;
      lsu_req_valid_r <= lsu_req_valid_n_s;
      rf_wen_r        <= rf_wen_n_s;
      halt_r          <= halt_n_s;
      halt_illegal_r  <= halt_illegal_n_s;
    end
  end

  assign pc            = pc_r;
  assign ifu_addr      = pc_r;
  assign inst_q        = inst_q_r;
  assign ifu_req_valid = ifu_req_valid_r;
  assign lsu_req_valid = lsu_req_valid_r;
  assign rf_wen        = rf_wen_r;
  assign halt          = halt_r;
  assign halt_illegal  = halt_illegal_r;

`ifdef CORE_CTRL_PERF_CNT_EN
  logic [63:0] perf_cycle_r;
  logic [63:0] perf_instret_r;

  // Cycle and retire counters; both wrap naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycle_r   <= 64'd0;
      perf_instret_r <= 64'd0;
    end else begin
      if (state_r != ST_HALT) begin
        perf_cycle_r <= perf_cycle_r + 64'd1;
      end else begin
        perf_cycle_r <= perf_cycle_r;
      end
      // ebreak counts as retired when it halts the core.
      if ((state_r == ST_WB) || ((state_r == ST_EXEC) && is_ebreak_s)) begin
        perf_instret_r <= perf_instret_r + 64'd1;
      end else begin
        perf_instret_r <= perf_instret_r;
      end
    end
  end

  assign perf_cycle   = perf_cycle_r;
  assign perf_instret = perf_instret_r;
`else
  assign perf_cycle   = 64'd0;
  assign perf_instret = 64'd0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_core_ctrl_fsm
//   Self-checking bench for core_ctrl_fsm. The bench plays instruction
//   memory, decoder, EXU and LSU. A transaction-level model tracks the
//   architectural PC, the latched word, retire/cycle counts and the expected
//   per-instruction latency, and every check goes through check_val.
// -----------------------------------------------------------------------------
module tb_core_ctrl_fsm;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic [31:0] inst_q;
  logic [15:0] dec_flags;
  logic        exu_br_taken;
  logic [31:0] exu_target;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        rf_wen;
  logic [31:0] pc;
  logic        halt;
  logic        halt_illegal;
  logic [63:0] perf_cycle;
  logic [63:0] perf_instret;

  core_ctrl_fsm #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data (ifu_rsp_data),
    .inst_q       (inst_q),
    .dec_flags    (dec_flags),
    .exu_br_taken (exu_br_taken),
    .exu_target   (exu_target),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .rf_wen       (rf_wen),
    .pc           (pc),
    .halt         (halt),
    .halt_illegal (halt_illegal),
    .perf_cycle   (perf_cycle),
    .perf_instret (perf_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  longint      m_cycle;
  longint      m_instret;
  bit          m_halted;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef CORE_CTRL_PERF_CNT_EN
    check_val({tag, "_cycle"}, perf_cycle, 64'(m_cycle));
    check_val({tag, "_instret"}, perf_instret, 64'(m_instret));
`else
    check_val({tag, "_cycle_tied"}, perf_cycle, 64'd0);
    check_val({tag, "_instret_tied"}, perf_instret, 64'd0);
`endif
  endtask

  // One clock: the model counts a cycle unless the core is halted.
  task automatic step();
    if (!m_halted) m_cycle++;
    @(posedge clk);
    #1;
    check_val("one_active",
              64'((ifu_req_valid & lsu_req_valid) | (ifu_req_valid & rf_wen) |
                  (lsu_req_valid & rf_wen)), 64'd0);
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_inst    = 32'h0;
    m_cycle   = 0;
    m_instret = 0;
    m_halted  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ifv"}, 64'(ifu_req_valid), 64'd0);
    check_val({tag, "_lsv"}, 64'(lsu_req_valid), 64'd0);
    check_val({tag, "_rfw"}, 64'(rf_wen), 64'd0);
    check_val({tag, "_halt"}, 64'(halt), 64'd0);
    check_val({tag, "_hill"}, 64'(halt_illegal), 64'd0);
    check_val({tag, "_pc"}, 64'(pc), 64'(RST_PC));
    check_val({tag, "_inst"}, 64'(inst_q), 64'd0);
    check_val({tag, "_pcyc"}, perf_cycle, 64'd0);
    check_val({tag, "_pret"}, perf_instret, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    model_reset();
  endtask

  // Runs one instruction through the core with the given wait profile.
  task automatic run_insn(input logic [31:0] word, input logic [15:0] flags,
                          input logic taken, input logic [31:0] target,
                          input int if_wait, input int rsp_wait, input int lsu_wait,
                          input bit rst_in_mem);
    int          lat;
    int          guard;
    int          exp_lat;
    bit          wr;
    bit          redirect;
    logic [31:0] exp_pc;
    dec_flags    = flags;
    exu_br_taken = taken;
    exu_target   = target;
    guard = 0;
    while (ifu_req_valid !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    check_val("fetch_valid", 64'(ifu_req_valid), 64'd1);
    check_val("fetch_addr", 64'(ifu_addr), 64'(m_pc));
    lat = 0;
    for (int i = 0; i < if_wait; i++) begin
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'($urandom_range(0, 1));
      ifu_rsp_data  = $urandom;
      step();
      lat++;
      check_val("addr_hold", 64'(ifu_addr), 64'(m_pc));
      check_val("valid_hold", 64'(ifu_req_valid), 64'd1);
      check_val("stray_ignored", 64'(inst_q), 64'(m_inst));
    end
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0;
    step();
    lat++;
    ifu_req_ready = 1'b0;
    check_val("fetch_drop", 64'(ifu_req_valid), 64'd0);
    for (int i = 0; i < rsp_wait; i++) begin
      step();
      lat++;
      check_val("inst_wait", 64'(inst_q), 64'(m_inst));
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = word;
    step();
    lat++;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = $urandom;
    m_inst = word;
    check_val("inst_q", 64'(inst_q), 64'(word));

    if (flags[15] || flags == 16'h0000) begin
      step();
      m_halted = 1'b1;
      if (flags[15]) m_instret++;
      check_val("halt", 64'(halt), 64'd1);
      check_val("halt_illegal", 64'(halt_illegal), 64'(flags == 16'h0000));
      check_val("halt_pc", 64'(pc), 64'(m_pc));
      for (int i = 0; i < 4; i++) begin
        ifu_req_ready = 1'b1;
        step();
        check_val("halt_no_fetch", 64'(ifu_req_valid), 64'd0);
        check_val("halt_stays", 64'(halt), 64'd1);
        check_val("halt_pc_frozen", 64'(pc), 64'(m_pc));
      end
      ifu_req_ready = 1'b0;
      check_perf("halt_perf");
      return;
    end

    if (flags[14]) begin
      step();
      lat++;
      check_val("lsu_valid", 64'(lsu_req_valid), 64'd1);
      for (int i = 0; i < lsu_wait; i++) begin
        lsu_req_ready = 1'b0;
        step();
        lat++;
        check_val("lsu_hold", 64'(lsu_req_valid), 64'd1);
      end
      if (rst_in_mem) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("mem_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      lsu_req_ready = 1'b1;
      step();
      lat++;
      lsu_req_ready = 1'b0;
      check_val("lsu_drop", 64'(lsu_req_valid), 64'd0);
    end else begin
      step();
      lat++;
    end

    wr = (|flags[7:0]) && (word[11:7] != 5'd0);
    check_val("rf_wen", 64'(rf_wen), 64'(wr));
    redirect = flags[6] || flags[7] || ((|flags[13:8]) && taken);
    exp_pc = redirect ? target : m_pc + 32'd4;
    step();
    lat++;
    m_pc = exp_pc;
    m_instret++;
    check_val("rf_wen_pulse", 64'(rf_wen), 64'd0);
    check_val("next_pc", 64'(pc), 64'(exp_pc));
    check_val("refetch", 64'(ifu_req_valid), 64'd1);
    exp_lat = 4 + if_wait + rsp_wait + (flags[14] ? 1 + lsu_wait : 0);
    check_val("latency", 64'(lat), 64'(exp_lat));
    check_perf("perf");
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] f;
    int          kind;
    rst           = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'h0;
    dec_flags     = 16'h0;
    exu_br_taken  = 1'b0;
    exu_target    = 32'h0;
    lsu_req_ready = 1'b0;
    model_reset();

    do_reset();
    // addi x1,x0,5 with zero-wait memory.
    run_insn(32'h0050_0093, 16'h0008, 1'b0, 32'h0, 0, 0, 0, 1'b0);
    // beq taken, then not taken.
    run_insn(32'h0000_0063, 16'h0100, 1'b1, 32'h8000_0100, 0, 0, 0, 1'b0);
    run_insn(32'h0000_0063, 16'h0100, 1'b0, 32'h8000_0200, 0, 0, 0, 1'b0);
    // sw with the LSU stalling three cycles.
    run_insn(32'h0010_a023, 16'h4000, 1'b0, 32'h0, 0, 0, 3, 1'b0);
    // Slow fetch acceptance with stray responses.
    run_insn(32'h0020_8133, 16'h0001, 1'b0, 32'h0, 5, 2, 0, 1'b0);
    // jal to the top of the address space, then a wrapping pc+4 with rd=x0.
    run_insn(32'h0000_00ef, 16'h0040, 1'b0, 32'hFFFF_FFFC, 0, 0, 0, 1'b0);
    run_insn(32'h0000_0013, 16'h0008, 1'b0, 32'h0, 0, 0, 0, 1'b0);

    // Randomized mix of ALU/jump, branch and store instructions.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      w = $urandom;
      w[11:7] = 5'($urandom_range(0, 3));
      if (kind == 0) f = 16'h0001 << $urandom_range(0, 7);
      else if (kind == 1) f = 16'h0001 << $urandom_range(8, 13);
      else f = 16'h4000;
      run_insn(w, f, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'b0);
    end

    // Three retired addi, then reset in the middle of a store.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      run_insn(32'h0050_0093, 16'h0008, 1'b0, 32'h0, 0, 0, 0, 1'b0);
    end
`ifdef CORE_CTRL_PERF_CNT_EN
    check_val("instret3", perf_instret, 64'd3);
`else
    check_val("instret3_tied", perf_instret, 64'd0);
`endif
    run_insn(32'h0010_a023, 16'h4000, 1'b0, 32'h0, 0, 0, 2, 1'b1);
    run_insn(32'h0050_0093, 16'h0008, 1'b0, 32'h0, 0, 0, 0, 1'b0);

    // ebreak that also raises jal: halts cleanly.
    run_insn(32'h0000_006f, 16'h8040, 1'b0, 32'h8000_0400, 0, 0, 0, 1'b0);
    // Undecodable word: illegal halt.
    do_reset();
    run_insn(32'hFFFF_FFFF, 16'h0000, 1'b0, 32'h0, 0, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
